// File: rtl/pc_sequencer_pkg.sv
// Core-wide definitions shared by the fetch sequencer and its next-PC datapath.
// Holds the sequencer state encoding, the sequential PC step and a word-alignment helper.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DECODE  = 2'd2,
        RESOLVE = 2'd3
    } seq_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Instruction addresses are word aligned; the two low bits never reach the pc.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_npc_calc.sv
// Next-PC datapath: sequential step, conditional branch target and J-type jump target.
// Purely combinational; jump has priority over a taken branch.
module npc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jtarget,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic [31:0] pc4_s;
    logic [31:0] br_offset_s;
    logic [31:0] br_target_s;
    logic [31:0] j_target_s;

    // Candidate targets; all sums are 32-bit so wrap-around falls out naturally.
    always_comb begin
        pc4_s       = pc + PC_STEP;
        br_offset_s = imm_ext << 2;
        br_target_s = pc4_s + br_offset_s;
        j_target_s  = {pc4_s[31:28], jtarget, 2'b00};
    end

    // Priority select: jump, then taken branch, then fall-through.
    always_comb begin
        next_pc = pc4_s;
        if (jump) begin
            next_pc = j_target_s;
        end else if (branch && zero) begin
            next_pc = br_target_s;
        end else begin
            next_pc = pc4_s;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch / decode-hold / resolve sequencer that owns the program counter.
// One fetch outstanding at a time; the next PC is computed only after execute resolves.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_ack,
    input  logic [31:0] if_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    input  logic        inst_ready,
    input  logic        resolve_valid,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jtarget,
    output logic [31:0] pc,
    output logic [31:0] retired
);

    localparam logic [31:0] RESET_PC_ALIGNED = align_pc(RESET_PC);

    seq_state_t  state_r;
    seq_state_t  next_state_s;
    logic        if_req_r;
    logic        inst_valid_r;
    logic        if_req_s;
    logic        inst_valid_s;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] retired_r;
    logic [31:0] next_pc_s;
    logic        capture_s;
    logic        advance_s;

    npc_calc u_npc_calc (
        .pc      (pc_r),
        .imm_ext (imm_ext),
        .jtarget (jtarget),
        .branch  (branch),
        .zero    (zero),
        .jump    (jump),
        .next_pc (next_pc_s)
    );

    // State register together with the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            if_req_r     <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            if_req_r     <= if_req_s;
            inst_valid_r <= inst_valid_s;
        end
    end

    // Next-state logic; each handshake input only matters in its own state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                next_state_s = FETCH;
            end
            FETCH: begin
                if (if_ack) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                if (inst_ready) begin
                    next_state_s = RESOLVE;
                end else begin
                    next_state_s = DECODE;
                end
            end
            RESOLVE: begin
                if (resolve_valid) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = RESOLVE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they appear registered alongside it.
    always_comb begin
        if_req_s     = 1'b0;
        inst_valid_s = 1'b0;
        case (next_state_s)
            FETCH: begin
                if_req_s = 1'b1;
            end
            DECODE: begin
                inst_valid_s = 1'b1;
            end
            IDLE, RESOLVE: begin
                if_req_s     = 1'b0;
                inst_valid_s = 1'b0;
            end
            default: begin
                if_req_s     = 1'b0;
                inst_valid_s = 1'b0;
            end
        endcase
    end

    // Qualified datapath strobes.
    always_comb begin
        capture_s = (state_r == FETCH)   && if_ack;
        advance_s = (state_r == RESOLVE) && resolve_valid;
    end

    // Program counter, instruction holding register and retirement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= RESET_PC_ALIGNED;
            inst_r    <= 32'h0000_0000;
            retired_r <= 32'h0000_0000;
        end else begin
            if (capture_s) begin
                inst_r <= if_rdata;
            end
            if (advance_s) begin
                pc_r      <= next_pc_s;
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    assign if_req     = if_req_r;
    assign inst_valid = inst_valid_r;
    assign if_addr    = pc_r;
    assign pc         = pc_r;
    assign inst       = inst_r;
    assign retired    = retired_r;

endmodule
